fp_mul_sched: RTL and testbench

FP_MUL_SCHED -- requirements
Module: fp_mul_sched

---
 rtl/fp_mul_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/fp_mul_sched.sv | 147 ++++++++++++++
 tb/tb_fp_mul_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types for the FP32 multiplier scheduler: operand width, default latency, tag format.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_mul_pkg;

  localparam int FP_W        = 32;
  localparam int MUL_LAT_DEF = 4;
  localparam int MAX_REQ     = 8;
  localparam int ID_MAX_W    = $clog2(MAX_REQ);

  // Requester index, sized for the largest supported requester count.
  typedef logic [ID_MAX_W-1:0] req_id_t;

  // One entry of the tag pipe that shadows the multiplier pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Grant arbiter: one-hot grant plus index, search starts just above ptr and wraps.
// Latency: combinational.
// Backpressure: en low or no request gives an all-zero grant.
module rr_arbiter
  import fp_mul_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]    req,
  input  logic                en,
  input  logic [ID_MAX_W-1:0] ptr,
  output logic [N_REQ-1:0]    gnt,
  output logic [ID_MAX_W-1:0] gnt_idx
);

  logic [N_REQ-1:0] req_v;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] pick;

  // Requests above ptr win first; otherwise wrap to the lowest requesting index.
  // With ptr = N_REQ-1 the upper set is empty, which is plain lowest-index priority.
  always_comb begin
    req_v  = en ? req : '0;
    req_hi = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_hi[i] = req_v[i] && (i > int'(ptr));
    end
    pick    = (req_hi != '0) ? req_hi : req_v;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = req_id_t'(i);
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one FP32 multiplier among N_REQ requesters; FP_MUL_SCHED_RR_EN selects round-robin, else fixed priority.
// Latency: response registered MUL_LAT+1 falling edges after acceptance; one op per cycle.
// Backpressure: req_ready grants at most one requester per cycle; responses have no backpressure.
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                           clk_n,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*FP_W-1:0]          req_a,
  input  logic [N_REQ*FP_W-1:0]          req_b,
  output logic [N_REQ-1:0]               req_ready,
  output logic [FP_W-1:0]                mul_a,
  output logic [FP_W-1:0]                mul_b,
  input  logic [FP_W-1:0]                mul_result,
  output logic                           rsp_valid,
  output logic [$clog2(N_REQ)-1:0]       rsp_id,
  output logic [FP_W-1:0]                rsp_data,
  output logic [$clog2(MUL_LAT+2)-1:0]   inflight
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MUL_LAT + 2);

  logic [N_REQ-1:0] gnt;
  req_id_t          gnt_idx;
  req_id_t          ptr;
  logic             accept;

  logic [FP_W-1:0]  mul_a_q, mul_a_d;
  logic [FP_W-1:0]  mul_b_q, mul_b_d;
  tag_t [MUL_LAT:0] tag_q, tag_d;
  tag_t             tail;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [FP_W-1:0]  rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .en      (en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

`ifdef FP_MUL_SCHED_RR_EN
  req_id_t ptr_q, ptr_d;

  // Pointer moves to the requester just served, so it becomes lowest priority next.
  always_comb begin
    ptr_d = accept ? gnt_idx : ptr_q;
  end

  // Pointer register; reset value gives requester 0 first priority.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) ptr_q <= req_id_t'(N_REQ - 1);
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  // Fixed pointer at the top index makes the arbiter pure lowest-index priority.
  assign ptr = req_id_t'(N_REQ - 1);
`endif

  // Operand mux: only the granted slice is captured; idle cycles present zeros.
  always_comb begin
    mul_a_d = '0;
    mul_b_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mul_a_d = req_a[FP_W*i +: FP_W];
        mul_b_d = req_b[FP_W*i +: FP_W];
      end
    end
  end

  // Tag pipe runs in lockstep with the multiplier; the tail lines up with mul_result.
  always_comb begin
    tag_d          = '0;
    tag_d[0].valid = accept;
    tag_d[0].id    = gnt_idx;
    for (int k = 1; k <= MUL_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  assign tail = tag_q[MUL_LAT];

  // Response capture: strobe follows the tail valid, id/data only load on a real result.
  always_comb begin
    rsp_valid_d = tail.valid;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (tail.valid) begin
      rsp_id_d   = ID_W'(tail.id);
      rsp_data_d = mul_result;
    end
  end

  // In-flight count: an op stops counting on the edge its response strobe goes out.
  always_comb begin
    inflight_d = inflight_q;
    case ({accept, rsp_valid_d})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Datapath and control state; reset discards every in-flight tag.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched with a behavioural 4-stage FP32 multiplier on the shared clk_n.
// Latency: checks response timing of MUL_LAT+1 falling edges after acceptance.
// Backpressure: exercises en gating, starvation and reset while ops are in flight.
module tb_fp_mul_sched;

  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 4;

  logic                   clk_n = 1'b1;
  logic                   rst_n;
  logic                   en;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*32-1:0]    req_a;
  logic [N_REQ*32-1:0]    req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [31:0]            mul_a;
  logic [31:0]            mul_b;
  logic [31:0]            mul_result;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [31:0]            rsp_data;
  logic [2:0]             inflight;

  always #5 clk_n = ~clk_n;

  fp_mul_sched #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk_n      (clk_n),
    .rst_n      (rst_n),
    .en         (en),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .inflight   (inflight)
  );

  // Behavioural multiplier: normal operands and zeros, truncating mantissa.
  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return {s, 8'(e + 1), p[46:24]};
    return {s, 8'(e), p[45:23]};
  endfunction

  logic [31:0] mpipe [MUL_LAT];
  always @(negedge clk_n) begin
    mpipe[0] <= fp32_mul(mul_a, mul_b);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    int          edge_n;
  } ev_t;

  ev_t rsp_q[$];
  ev_t gnt_q[$];
  int  edge_cnt = 0;

  always @(negedge clk_n) edge_cnt <= edge_cnt + 1;

  // Mid-cycle monitor: logs responses and grants (grant edge_n = accepting edge).
  always @(posedge clk_n) begin
    ev_t ev;
    if (rsp_valid) begin
      ev.id = int'(rsp_id);
      ev.data = rsp_data;
      ev.edge_n = edge_cnt;
      rsp_q.push_back(ev);
    end
    if (rst_n && (req_ready != '0)) begin
      chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      ev.id = 0;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) ev.id = i;
      ev.data = '0;
      ev.edge_n = edge_cnt + 1;
      gnt_q.push_back(ev);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_n);
    #2;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic clear_logs();
    rsp_q.delete();
    gnt_q.delete();
  endtask

  logic [31:0] bvals [4];
  int          exp_t2 [8];
  int          exp_t3 [6];

  initial begin
    bvals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
`ifdef FP_MUL_SCHED_RR_EN
    exp_t2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_t3 = '{1, 3, 1, 3, 3, 3};
`else
    exp_t2 = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_t3 = '{1, 1, 1, 1, 3, 3};
`endif

    rst_n = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    step(1);
    rst_n = 1'b1;
    en = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    step(1);

    // 2.0 * 3.0 from requester 0
    clear_logs();
    set_op(0, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    step(1);
    req_valid = '0;
    chk("t1_mul_a", mul_a, 32'h40000000);
    chk("t1_mul_b", mul_b, 32'h40400000);
    chk("t1_inflight", 32'(inflight), 32'd1);
    step(6);
    chk("t1_nrsp", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0 && gnt_q.size() > 0) begin
      chk("t1_id", 32'(rsp_q[0].id), 32'd0);
      chk("t1_data", rsp_q[0].data, 32'h40C00000);
      chk("t1_lat", 32'(rsp_q[0].edge_n - gnt_q[0].edge_n), 32'd5);
    end
    chk("t1_inflight_end", 32'(inflight), 32'd0);
    chk("t1_rsp_valid_end", 32'(rsp_valid), 32'd0);

    // All four requesters valid for 8 cycles
    do_reset();
    clear_logs();
    for (int i = 0; i < N_REQ; i++) set_op(i, 32'h3F800000, bvals[i]);
    req_valid = 4'b1111;
    step(8);
    req_valid = '0;
    step(8);
    chk("t2_ngnt", 32'(gnt_q.size()), 32'd8);
    chk("t2_nrsp", 32'(rsp_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < gnt_q.size()) chk($sformatf("t2_gnt%0d", k), 32'(gnt_q[k].id), 32'(exp_t2[k]));
      if (k < rsp_q.size()) begin
        chk($sformatf("t2_rid%0d", k), 32'(rsp_q[k].id), 32'(exp_t2[k]));
        chk($sformatf("t2_rdat%0d", k), rsp_q[k].data, bvals[exp_t2[k]]);
        chk($sformatf("t2_redge%0d", k), 32'(rsp_q[k].edge_n - rsp_q[0].edge_n), 32'(k));
      end
    end
    if (rsp_q.size() > 0 && gnt_q.size() > 0)
      chk("t2_lat", 32'(rsp_q[0].edge_n - gnt_q[0].edge_n), 32'd5);

    // Requesters 1 and 3 contending, then 1 drops
    clear_logs();
    set_op(1, 32'h3F800000, 32'h40000000);
    set_op(3, 32'h3F800000, 32'h40800000);
    req_valid = 4'b1010;
    step(4);
    req_valid = 4'b1000;
    step(2);
    req_valid = '0;
    step(8);
    chk("t3_ngnt", 32'(gnt_q.size()), 32'd6);
    chk("t3_nrsp", 32'(rsp_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < gnt_q.size()) chk($sformatf("t3_gnt%0d", k), 32'(gnt_q[k].id), 32'(exp_t3[k]));
    end

    // Requester 2: 1.5 * 0.0 then 1.5 * 1.5
    clear_logs();
    set_op(2, 32'h3FC00000, 32'h00000000);
    req_valid = 4'b0100;
    #1;
    chk("t4_ready", 32'(req_ready), 32'h4);
    step(1);
    set_op(2, 32'h3FC00000, 32'h3FC00000);
    step(1);
    req_valid = '0;
    step(7);
    chk("t4_nrsp", 32'(rsp_q.size()), 32'd2);
    if (rsp_q.size() > 1) begin
      chk("t4_id0", 32'(rsp_q[0].id), 32'd2);
      chk("t4_dat0", rsp_q[0].data, 32'h00000000);
      chk("t4_id1", 32'(rsp_q[1].id), 32'd2);
      chk("t4_dat1", rsp_q[1].data, 32'h40100000);
      chk("t4_edge", 32'(rsp_q[1].edge_n - rsp_q[0].edge_n), 32'd1);
    end

    // Three ops, then en low while the request stays up
    clear_logs();
    req_valid = 4'b0001;
    set_op(0, 32'h3F800000, 32'h40000000);
    step(1);
    set_op(0, 32'h3F800000, 32'h40400000);
    step(1);
    set_op(0, 32'h3F800000, 32'h40800000);
    step(1);
    en = 1'b0;
    #1;
    chk("t5_ready_off", 32'(req_ready), 32'd0);
    chk("t5_inflight3", 32'(inflight), 32'd3);
    step(2);
    chk("t5_inflight_e5", 32'(inflight), 32'd3);
    step(1);
    chk("t5_inflight_e6", 32'(inflight), 32'd2);
    step(2);
    chk("t5_inflight_e8", 32'(inflight), 32'd0);
    step(3);
    chk("t5_ngnt", 32'(gnt_q.size()), 32'd3);
    chk("t5_nrsp", 32'(rsp_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < rsp_q.size() && gnt_q.size() > 0) begin
        chk($sformatf("t5_dat%0d", k), rsp_q[k].data, bvals[k+1]);
        chk($sformatf("t5_lat%0d", k), 32'(rsp_q[k].edge_n - gnt_q[0].edge_n), 32'(5 + k));
      end
    end
    req_valid = '0;
    en = 1'b1;

    // Reset with two ops in flight
    clear_logs();
    set_op(1, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0010;
    step(2);
    req_valid = '0;
    chk("t6_inflight_pre", 32'(inflight), 32'd2);
    do_reset();
    step(8);
    chk("t6_nrsp", 32'(rsp_q.size()), 32'd0);
    chk("t6_inflight", 32'(inflight), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_mul_a", mul_a, 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("t6_first_gnt", 32'(req_ready), 32'h1);
    step(1);
    req_valid = '0;
    step(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
